// File: rtl/slt_serial_32.sv
// slt_serial_32: bit-serial magnitude comparator.
// Scans the captured operands from MSB to LSB, one bit per cycle, and stops
// at the first differing bit. The result word uses the set-less-than format
// {WIDTH-1 zeros, lt}. The lt/eq/gt flags and the result word update only
// on the edge that enters DONE.
module slt_serial_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sgn_r;
  logic [IDX_W-1:0] idx_r;

  logic a_bit_s;
  logic b_bit_s;
  logic bits_differ_s;
  logic at_lsb_s;
  logic a_greater_s;

  // Examine the current bit pair; the sign bit of a signed compare inverts
  // the sense of "bit set means larger".
  always_comb begin
    a_bit_s       = a_r[idx_r];
    b_bit_s       = b_r[idx_r];
    bits_differ_s = a_bit_s ^ b_bit_s;
    at_lsb_s      = (idx_r == IDX_ZERO);
    if ((idx_r == IDX_MSB) && sgn_r) begin
      a_greater_s = ~a_bit_s;
    end else begin
      a_greater_s = a_bit_s;
    end
  end

  // Control FSM with operand capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sgn_r   <= 1'b0;
      idx_r   <= IDX_ZERO;
      busy    <= 1'b0;
      done    <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      result  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          // DONE is a single-cycle pulse; a start here begins the next scan
          // immediately without passing through IDLE.
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            sgn_r   <= sgn;
            idx_r   <= IDX_MSB;
            state_r <= RUN;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          // start is deliberately ignored while scanning.
          if (bits_differ_s) begin
            lt      <= ~a_greater_s;
            gt      <= a_greater_s;
            eq      <= 1'b0;
            result  <= {{(WIDTH-1){1'b0}}, ~a_greater_s};
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (at_lsb_s) begin
            lt      <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b1;
            result  <= {WIDTH{1'b0}};
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            idx_r   <= idx_r - IDX_ONE;
            state_r <= RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slt_serial_32.sv
// Self-checking bench for slt_serial_32: directed scenarios plus random
// compares against a reference model built from plain signed/unsigned
// comparison and the highest-differing-bit latency rule.
module tb_slt_serial_32;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             lt;
  logic             eq;
  logic             gt;

  int tests = 0;
  int fails = 0;

  // Last completed result, as the outputs must hold it between completions.
  logic m_lt = 1'b0;
  logic m_eq = 1'b0;
  logic m_gt = 1'b0;

  slt_serial_32 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from accept edge to result edge: WIDTH minus the index of the
  // highest differing bit, or WIDTH when the operands are equal.
  function automatic int model_n(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int n;
    n = WIDTH;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i] !== y[i]) n = WIDTH - i;
    end
    return n;
  endfunction

  // Issue one compare; returns in the done cycle. inject >= 0 pulses a
  // competing start that many cycles into the scan.
  task automatic run_cmp(input string tag, input logic s, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input int inject);
    logic e_lt, e_eq, e_gt, seen;
    int   n, k;
    n    = model_n(x, y);
    e_lt = s ? ($signed(x) < $signed(y)) : (x < y);
    e_gt = s ? ($signed(x) > $signed(y)) : (x > y);
    e_eq = (x == y);
    start = 1'b1; sgn = s; a = x; b = y;
    step();
    start = 1'b0;
    chk({tag, ":accept_busy"}, busy, 1);
    chk({tag, ":accept_done"}, done, 0);
    a = $urandom; b = $urandom; sgn = 1'($urandom);
    k = 0; seen = 1'b0;
    while (k < WIDTH + 4 && !seen) begin
      if (k == inject) begin
        start = 1'b1; a = 32'd0; b = 32'd1;
      end
      step();
      start = 1'b0;
      k++;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        chk({tag, ":run_busy"}, busy, 1);
        chk({tag, ":run_hold"}, {lt, eq, gt}, {m_lt, m_eq, m_gt});
      end
    end
    chk({tag, ":timeout"}, seen, 1);
    if (seen) begin
      chk({tag, ":latency"}, k, n);
      chk({tag, ":done_busy"}, busy, 0);
      chk({tag, ":flags"}, {lt, eq, gt}, {e_lt, e_eq, e_gt});
      chk({tag, ":result"}, result, {{(WIDTH-1){1'b0}}, e_lt});
    end
    m_lt = e_lt; m_eq = e_eq; m_gt = e_gt;
  endtask

  // After a done cycle with no new start: pulse must end, unit idle.
  task automatic idle_after(input string tag);
    step();
    chk({tag, ":pulse_end"}, done, 0);
    chk({tag, ":idle_busy"}, busy, 0);
    chk({tag, ":idle_hold"}, {lt, eq, gt}, {m_lt, m_eq, m_gt});
  endtask

  initial begin
    logic             s, dseen;
    logic [WIDTH-1:0] x, y;
    int               mode;

    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    step();
    step();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_flags", {lt, eq, gt}, 3'b000);
    chk("reset_result", result, 0);
    rst = 1'b0;
    step();

    run_cmp("uns_msb", 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, -1);
    idle_after("uns_msb");
    run_cmp("sgn_msb", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, -1);
    idle_after("sgn_msb");

    // Abort a scan with reset; outputs return to reset values, no done.
    start = 1'b1; sgn = 1'b0; a = '0; b = '0;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("abort_pre_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", {lt, eq, gt}, 3'b000);
    m_lt = 1'b0; m_eq = 1'b0; m_gt = 1'b0;
    dseen = 1'b0;
    repeat (40) begin
      step();
      if (done === 1'b1) dseen = 1'b1;
    end
    chk("abort_no_done", dseen, 0);

    run_cmp("equal", 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, -1);
    idle_after("equal");
    run_cmp("lsb_ign", 1'b0, 32'd5, 32'd4, 5);
    // Back-to-back: the next start is driven in this done cycle.
    run_cmp("b2b", 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFE, -1);
    idle_after("b2b");

    for (int t = 0; t < 40; t++) begin
      s    = 1'($urandom);
      x    = $urandom;
      mode = $urandom_range(0, 2);
      case (mode)
        0:       y = $urandom;
        1:       y = x;
        default: y = x ^ (32'd1 << $urandom_range(0, WIDTH - 1));
      endcase
      run_cmp("rand", s, x, y, -1);
      if ($urandom_range(0, 1) == 0) idle_after("rand");
    end
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
